wb_stage_mlane: RTL and testbench

//  Multi-lane writeback stage that retires groups of LANES results from MEM into a

---
 rtl/wb_stage_mlane_pkg.sv | 32 +++
 rtl/wb_stage_mlane_if.sv | 36 +++
 rtl/wb_stage_mlane_group_fifo.sv | 78 +++++++
 rtl/wb_stage_mlane.sv | 105 ++++++++++
 tb/tb_wb_stage_mlane.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_stage_mlane_pkg.sv
// Shared widths, lane/forwarding payload layouts and the result-select helper
// for the multi-lane writeback stage.
package wb_stage_mlane_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned PC_W   = 32;
  localparam int unsigned LANE_W = PC_W + 1 + ADDR_W + 2 * DATA_W + 1;
  localparam int unsigned FWD_W  = ADDR_W + 1 + DATA_W;

  // One lane of a MEM->WB group; first member sits in the MSBs.
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic              gr_we;
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] mem_result;
    logic [DATA_W-1:0] alu_result;
    logic              rfrom_mem;
  } lane_t;

  // One forwarding slot as seen by ID.
  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic              rfrom_mem;
    logic [DATA_W-1:0] result;
  } fwd_t;

  function automatic logic [DATA_W-1:0] lane_result(input lane_t ln);
    return ln.rfrom_mem ? ln.mem_result : ln.alu_result;
  endfunction

endpackage

// File: rtl/wb_stage_mlane_if.sv
// MEM->WB handshake, register-file write port, forwarding and debug trace bundle.
interface wb_stage_mlane_if
  import wb_stage_mlane_pkg::*;
#(
  parameter int unsigned LANES = 2,
  parameter int unsigned DEPTH = 2
) ();

  logic                           mem_valid;
  logic                           wb_allowin;
  logic [LANES-1:0]               mem_lane_vld;
  logic [LANES*LANE_W-1:0]        mem_bus;
  logic                           flush;
  logic                           rf_we;
  logic [ADDR_W-1:0]              rf_waddr;
  logic [DATA_W-1:0]              rf_wdata;
  logic [DEPTH*LANES*FWD_W-1:0]   wb_fwd_bus;
  logic                           wb_busy;
  logic [PC_W-1:0]                debug_wb_pc;
  logic [3:0]                     debug_wb_rf_we;
  logic [ADDR_W-1:0]              debug_wb_rf_wnum;
  logic [DATA_W-1:0]              debug_wb_rf_wdata;

  modport master (
    output mem_valid, mem_lane_vld, mem_bus, flush,
    input  wb_allowin, rf_we, rf_waddr, rf_wdata, wb_fwd_bus, wb_busy,
    input  debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata
  );

  modport slave (
    input  mem_valid, mem_lane_vld, mem_bus, flush,
    output wb_allowin, rf_we, rf_waddr, rf_wdata, wb_fwd_bus, wb_busy,
    output debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata
  );

endinterface

// File: rtl/wb_stage_mlane_group_fifo.sv
// DEPTH-entry ring of lane groups, each with a pending-lane mask; slots are
// presented oldest-first so slot 0 is always the head.
module wb_stage_mlane_group_fifo
  import wb_stage_mlane_pkg::*;
#(
  parameter int unsigned LANES = 2,
  parameter int unsigned DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic [LANES*LANE_W-1:0] push_data,
  input  logic [LANES-1:0]        push_pend,
  input  logic                    retire,
  input  logic [LANES-1:0]        retire_mask,
  input  logic                    pop,
  input  logic                    flush,
  output logic [LANES*LANE_W-1:0] slot_data [DEPTH],
  output logic [LANES-1:0]        slot_pend [DEPTH],
  output logic [DEPTH-1:0]        slot_occ,
  output logic                    full
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [LANES*LANE_W-1:0] data_q [DEPTH];
  logic [LANES-1:0]        pend_q [DEPTH];
  logic [PTR_W-1:0]        rd_q;
  logic [PTR_W-1:0]        wr_q;
  logic [CNT_W-1:0]        count_q;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A push into the entry being popped overrides the retire update of that entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_q[i] <= '0;
        pend_q[i] <= '0;
      end
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else if (flush) begin
      for (int i = 0; i < int'(DEPTH); i++) pend_q[i] <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (retire) pend_q[rd_q] <= pend_q[rd_q] & ~retire_mask;
      if (push) begin
        data_q[wr_q] <= push_data;
        pend_q[wr_q] <= push_pend;
        wr_q         <= next_ptr(wr_q);
      end
      if (pop) rd_q <= next_ptr(rd_q);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Rotate physical entries into oldest-first slot order.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int unsigned e = 0; e < DEPTH; e++) begin
      idx          = rd_q + PTR_W'(e);
      slot_data[e] = data_q[idx];
      slot_pend[e] = pend_q[idx];
      slot_occ[e]  = CNT_W'(e) < count_q;
    end
  end

  assign full = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/wb_stage_mlane.sv
// Multi-lane writeback: buffers MEM groups and retires one pending lane per
// cycle through the single register-file write port.
module wb_stage_mlane
  import wb_stage_mlane_pkg::*;
#(
  parameter int unsigned LANES = 2,
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  wb_stage_mlane_if.slave bus
);

  logic [LANES*LANE_W-1:0] slot_data [DEPTH];
  logic [LANES-1:0]        slot_pend [DEPTH];
  logic [DEPTH-1:0]        slot_occ;
  lane_t                   slot_lane [DEPTH][LANES];
  logic                    full;
  logic                    found;
  logic                    retire;
  logic                    pop;
  logic                    push;
  logic                    allowin;
  logic                    we;
  logic [LANES-1:0]        retire_mask;
  lane_t                   cur;
  logic [PC_W-1:0]         last_pc;
  logic [DEPTH*LANES*FWD_W-1:0] fwd;

  wb_stage_mlane_group_fifo #(.LANES(LANES), .DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .push_data   (bus.mem_bus),
    .push_pend   (bus.mem_lane_vld),
    .retire      (retire),
    .retire_mask (retire_mask),
    .pop         (pop),
    .flush       (bus.flush),
    .slot_data   (slot_data),
    .slot_pend   (slot_pend),
    .slot_occ    (slot_occ),
    .full        (full)
  );

  always_comb begin
    for (int unsigned e = 0; e < DEPTH; e++)
      for (int unsigned l = 0; l < LANES; l++)
        slot_lane[e][l] = lane_t'(slot_data[e][l*LANE_W +: LANE_W]);
  end

  // Lowest-index pending lane of the head group.
  always_comb begin
    found       = 1'b0;
    retire_mask = '0;
    cur         = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (!found && slot_pend[0][l]) begin
        found          = 1'b1;
        retire_mask[l] = 1'b1;
        cur            = slot_lane[0][l];
      end
    end
  end

  // Nothing retires in a flush cycle; the whole buffer is dropped at the edge.
  assign retire  = found & ~bus.flush;
  assign pop     = retire & ((slot_pend[0] & ~retire_mask) == '0);
  assign allowin = ~full | pop;
  assign push    = bus.mem_valid & allowin & (|bus.mem_lane_vld) & ~bus.flush;
  assign we      = retire & cur.gr_we;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       last_pc <= '0;
    else if (retire) last_pc <= cur.pc;
  end

  // Slot (e,l) only advertises a dest that is still going to be written.
  always_comb begin
    fwd_t f;
    fwd = '0;
    f   = '0;
    for (int unsigned e = 0; e < DEPTH; e++) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        f.dest      = (slot_occ[e] & slot_pend[e][l] & slot_lane[e][l].gr_we)
                      ? slot_lane[e][l].dest : '0;
        f.rfrom_mem = slot_lane[e][l].rfrom_mem;
        f.result    = lane_result(slot_lane[e][l]);
        fwd[(e*LANES+l)*FWD_W +: FWD_W] = f;
      end
    end
  end

  assign bus.wb_allowin        = allowin;
  assign bus.rf_we             = we;
  assign bus.rf_waddr          = we ? cur.dest : '0;
  assign bus.rf_wdata          = we ? lane_result(cur) : '0;
  assign bus.wb_fwd_bus        = fwd;
  assign bus.wb_busy           = slot_occ[0];
  assign bus.debug_wb_pc       = retire ? cur.pc : last_pc;
  assign bus.debug_wb_rf_we    = {4{we}};
  assign bus.debug_wb_rf_wnum  = bus.rf_waddr;
  assign bus.debug_wb_rf_wdata = bus.rf_wdata;

endmodule

// File: tb/tb_wb_stage_mlane.sv
// Bench for wb_stage_mlane: directed vector table, corner-case sequences and
// randomized traffic against a queue-of-groups reference model.
module tb_wb_stage_mlane;
  import wb_stage_mlane_pkg::*;

  localparam int unsigned LANES = 2;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned BUS_W = LANES * LANE_W;
  localparam int unsigned DST_W = DEPTH * LANES * ADDR_W;

  logic clk;
  logic reset;

  wb_stage_mlane_if #(.LANES(LANES), .DEPTH(DEPTH)) bus ();
  wb_stage_mlane #(.LANES(LANES), .DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [LANES-1:0] pend;
    logic [BUS_W-1:0] data;
  } grp_t;

  grp_t            q[$];
  logic [PC_W-1:0] m_last_pc;

  logic             in_valid, in_flush;
  logic [LANES-1:0] in_vld;
  logic [BUS_W-1:0] in_data;

  logic              e_we, e_allow, e_busy, m_retire, m_pop, m_accept;
  logic [ADDR_W-1:0] e_waddr;
  logic [DATA_W-1:0] e_wdata;
  logic [PC_W-1:0]   e_pc;
  logic [DST_W-1:0]  e_fwd;
  int                m_lane;

  typedef struct {
    logic              v;
    logic [LANES-1:0]  vld;
    lane_t             l0;
    lane_t             l1;
    logic              fl;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [PC_W-1:0]   pc;
    logic              busy;
    logic              allow;
    logic [DST_W-1:0]  fwd;
  } vec_t;

  vec_t tv[9];

  function automatic lane_t mk(input logic [PC_W-1:0] pc, input logic we,
                               input logic [ADDR_W-1:0] dest, input logic [DATA_W-1:0] mem,
                               input logic [DATA_W-1:0] alu, input logic rfm);
    lane_t ln;
    ln.pc = pc; ln.gr_we = we; ln.dest = dest;
    ln.mem_result = mem; ln.alu_result = alu; ln.rfrom_mem = rfm;
    return ln;
  endfunction

  function automatic lane_t rnd_lane();
    return mk($urandom, 1'($urandom), 5'($urandom), $urandom, $urandom, 1'($urandom));
  endfunction

  function automatic logic [DST_W-1:0] act_fwd();
    logic [DST_W-1:0] r;
    fwd_t f;
    r = '0;
    for (int k = 0; k < int'(DEPTH * LANES); k++) begin
      f = fwd_t'(bus.wb_fwd_bus[k*FWD_W +: FWD_W]);
      r[k*ADDR_W +: ADDR_W] = f.dest;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected outputs for this cycle from the queued groups and current inputs.
  task automatic model_eval();
    grp_t  g;
    lane_t ln;
    e_we = 1'b0; e_waddr = '0; e_wdata = '0; e_pc = m_last_pc;
    m_retire = 1'b0; m_pop = 1'b0; m_lane = 0; e_fwd = '0;
    if (q.size() != 0) begin
      g = q[0];
      for (int l = int'(LANES) - 1; l >= 0; l--) if (g.pend[l]) m_lane = l;
      ln = lane_t'(g.data[m_lane*LANE_W +: LANE_W]);
      if (!in_flush) begin
        m_retire = 1'b1;
        e_we     = ln.gr_we;
        e_pc     = ln.pc;
        e_waddr  = ln.dest;
        e_wdata  = ln.rfrom_mem ? ln.mem_result : ln.alu_result;
        m_pop    = ($countones(g.pend) == 1);
      end
    end
    e_busy  = (q.size() != 0);
    e_allow = (q.size() < int'(DEPTH)) || m_pop;
    for (int e = 0; e < q.size(); e++)
      for (int l = 0; l < int'(LANES); l++) begin
        ln = lane_t'(q[e].data[l*LANE_W +: LANE_W]);
        if (q[e].pend[l] && ln.gr_we) e_fwd[(e*LANES+l)*ADDR_W +: ADDR_W] = ln.dest;
      end
    m_accept = in_valid && e_allow && !in_flush;
  endtask

  task automatic model_edge();
    grp_t g;
    if (in_flush) q.delete();
    else begin
      if (m_retire) begin
        g = q[0];
        g.pend[m_lane] = 1'b0;
        m_last_pc = e_pc;
        if (g.pend == '0) void'(q.pop_front());
        else q[0] = g;
      end
      if (m_accept && in_vld != '0) begin
        g.pend = in_vld;
        g.data = in_data;
        q.push_back(g);
      end
    end
  endtask

  task automatic drive(input logic v, input logic [LANES-1:0] vld,
                       input logic [BUS_W-1:0] data, input logic fl);
    in_valid = v; in_vld = vld; in_data = data; in_flush = fl;
    bus.mem_valid = v; bus.mem_lane_vld = vld; bus.mem_bus = data; bus.flush = fl;
  endtask

  task automatic step(input logic v, input logic [LANES-1:0] vld,
                      input logic [BUS_W-1:0] data, input logic fl);
    @(negedge clk);
    drive(v, vld, data, fl);
    #1;
    model_eval();
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    model_edge();
  endtask

  task automatic check_model();
    chk("rf_we", 64'(bus.rf_we), 64'(e_we));
    chk("dbg_rf_we", 64'(bus.debug_wb_rf_we), 64'({4{e_we}}));
    if (e_we) begin
      chk("rf_waddr", 64'(bus.rf_waddr), 64'(e_waddr));
      chk("rf_wdata", 64'(bus.rf_wdata), 64'(e_wdata));
      chk("dbg_wnum", 64'(bus.debug_wb_rf_wnum), 64'(e_waddr));
      chk("dbg_wdata", 64'(bus.debug_wb_rf_wdata), 64'(e_wdata));
    end
    chk("dbg_pc", 64'(bus.debug_wb_pc), 64'(e_pc));
    chk("allowin", 64'(bus.wb_allowin), 64'(e_allow));
    chk("busy", 64'(bus.wb_busy), 64'(e_busy));
    chk("fwd_dest", 64'(act_fwd()), 64'(e_fwd));
  endtask

  initial begin
    lane_t a0, a1, b0, b1, c0, c1, z;
    logic [BUS_W-1:0] grp;
    int stalls;
    logic need_new;

    a0 = mk(32'h1c000000, 1'b1, 5'd3, 32'h0,  32'h11, 1'b0);
    a1 = mk(32'h1c000004, 1'b1, 5'd4, 32'h22, 32'h0,  1'b1);
    b0 = mk(32'h1c000010, 1'b1, 5'd5, 32'h0,  32'h55, 1'b0);
    b1 = mk(32'h1c000014, 1'b1, 5'd6, 32'h0,  32'h66, 1'b0);
    c0 = mk(32'h1c000020, 1'b0, 5'd9, 32'h0,  32'h99, 1'b0);
    c1 = mk(32'h1c000024, 1'b1, 5'd7, 32'h77, 32'h0,  1'b1);
    z  = '0;
    //         v     vld    l0  l1  fl    we    waddr  wdata   pc            busy  allow fwd
    tv[0] = '{1'b1, 2'b11, a0, a1, 1'b0, 1'b0, 5'd0, 32'h00, 32'h0,        1'b0, 1'b1, 20'h00};
    tv[1] = '{1'b0, 2'b00, z,  z,  1'b0, 1'b1, 5'd3, 32'h11, 32'h1c000000, 1'b1, 1'b1, 20'h83};
    tv[2] = '{1'b0, 2'b00, z,  z,  1'b0, 1'b1, 5'd4, 32'h22, 32'h1c000004, 1'b1, 1'b1, 20'h80};
    tv[3] = '{1'b1, 2'b10, b0, b1, 1'b0, 1'b0, 5'd0, 32'h00, 32'h1c000004, 1'b0, 1'b1, 20'h00};
    tv[4] = '{1'b0, 2'b00, z,  z,  1'b0, 1'b1, 5'd6, 32'h66, 32'h1c000014, 1'b1, 1'b1, 20'hc0};
    tv[5] = '{1'b1, 2'b11, c0, c1, 1'b0, 1'b0, 5'd0, 32'h00, 32'h1c000014, 1'b0, 1'b1, 20'h00};
    tv[6] = '{1'b0, 2'b00, z,  z,  1'b0, 1'b0, 5'd0, 32'h00, 32'h1c000020, 1'b1, 1'b1, 20'he0};
    tv[7] = '{1'b0, 2'b00, z,  z,  1'b0, 1'b1, 5'd7, 32'h77, 32'h1c000024, 1'b1, 1'b1, 20'he0};
    tv[8] = '{1'b0, 2'b00, z,  z,  1'b0, 1'b0, 5'd0, 32'h00, 32'h1c000024, 1'b0, 1'b1, 20'h00};

    m_last_pc = '0;
    reset = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    #2;
    chk("rst_busy", 64'(bus.wb_busy), 64'd0);
    chk("rst_we", 64'(bus.rf_we), 64'd0);
    chk("rst_allowin", 64'(bus.wb_allowin), 64'd1);
    chk("rst_pc", 64'(bus.debug_wb_pc), 64'd0);
    chk("rst_fwd", 64'(act_fwd()), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed table: two-lane group, single upper lane, non-writing lane 0.
    for (int i = 0; i < 9; i++) begin
      step(tv[i].v, tv[i].vld, {tv[i].l1, tv[i].l0}, tv[i].fl);
      chk($sformatf("tv%0d_we", i), 64'(bus.rf_we), 64'(tv[i].we));
      if (tv[i].we) begin
        chk($sformatf("tv%0d_waddr", i), 64'(bus.rf_waddr), 64'(tv[i].waddr));
        chk($sformatf("tv%0d_wdata", i), 64'(bus.rf_wdata), 64'(tv[i].wdata));
      end
      chk($sformatf("tv%0d_pc", i), 64'(bus.debug_wb_pc), 64'(tv[i].pc));
      chk($sformatf("tv%0d_busy", i), 64'(bus.wb_busy), 64'(tv[i].busy));
      chk($sformatf("tv%0d_allow", i), 64'(bus.wb_allowin), 64'(tv[i].allow));
      chk($sformatf("tv%0d_fwd", i), 64'(act_fwd()), 64'(tv[i].fwd));
      finish_cycle();
    end

    // Back-to-back two-lane groups: backpressure must appear, nothing lost.
    stalls = 0;
    grp = {rnd_lane(), rnd_lane()};
    repeat (12) begin
      step(1'b1, 2'b11, grp, 1'b0);
      check_model();
      if (!bus.wb_allowin) stalls++;
      if (m_accept) grp = {rnd_lane(), rnd_lane()};
      finish_cycle();
    end
    chk("b2b_stall_seen", 64'(stalls > 0), 64'd1);

    // Fill the buffer, then flush with a group on the input.
    for (int k = 0; k < 8 && q.size() < int'(DEPTH); k++) begin
      step(1'b1, 2'b11, grp, 1'b0);
      check_model();
      if (m_accept) grp = {rnd_lane(), rnd_lane()};
      finish_cycle();
    end
    chk("flush_prefill", 64'(q.size()), 64'(DEPTH));
    step(1'b1, 2'b11, grp, 1'b1);
    chk("flush_cycle_we", 64'(bus.rf_we), 64'd0);
    check_model();
    finish_cycle();
    step(1'b0, '0, '0, 1'b0);
    chk("flush_busy", 64'(bus.wb_busy), 64'd0);
    chk("flush_fwd", 64'(act_fwd()), 64'd0);
    check_model();
    finish_cycle();

    // Asynchronous reset mid-drain, checked before the next clock edge.
    step(1'b1, 2'b11, {rnd_lane(), mk(32'h1c000100, 1'b1, 5'd9, 32'h0, 32'h5, 1'b0)}, 1'b0);
    check_model();
    finish_cycle();
    step(1'b0, '0, '0, 1'b0);
    check_model();
    #1 reset = 1'b1;
    #1;
    chk("areset_busy", 64'(bus.wb_busy), 64'd0);
    chk("areset_we", 64'(bus.rf_we), 64'd0);
    chk("areset_pc", 64'(bus.debug_wb_pc), 64'd0);
    chk("areset_allowin", 64'(bus.wb_allowin), 64'd1);
    chk("areset_fwd", 64'(act_fwd()), 64'd0);
    reset = 1'b0;
    q.delete();
    m_last_pc = '0;
    @(posedge clk);
    step(1'b0, '0, '0, 1'b0);
    check_model();
    finish_cycle();

    // Random traffic: sparse lanes, empty groups, stalls and occasional flushes.
    need_new = 1'b1;
    repeat (300) begin
      logic v, fl;
      logic [LANES-1:0] vld;
      if (need_new) begin
        grp = {rnd_lane(), rnd_lane()};
        vld = LANES'($urandom);
        need_new = 1'b0;
      end
      v  = ($urandom % 4) != 0;
      fl = ($urandom % 16) == 0;
      step(v, vld, grp, fl);
      check_model();
      if (m_accept) need_new = 1'b1;
      finish_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
